// File: rtl/tl_timer_pkg.sv
// Shared definitions for the traffic-light interval timer: interval codes,
// FSM state encoding and default datapath widths.
package tl_timer_pkg;

    localparam int VALUE_W_DEF    = 4;
    localparam int INTERVAL_W_DEF = 2;

    // Interval select codes understood by TimeParameter; code 2'b11 is passed
    // through untouched and has no dedicated name.
    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        LOAD = 2'b10,
        RUN  = 2'b11
    } timer_state_e;

endpackage

// File: rtl/sec_tick_divider.sv
// Free-running 0..CLK_PER_SEC-1 divider; tick is high while it sits on the
// last count. clr restarts the second so the next tick is a full period away.
module sec_tick_divider #(
    parameter int CLK_PER_SEC = 10
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SEC - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/interval_timer.sv
// Interval countdown engine: requests an interval from TimeParameter, loads
// the returned seconds value and counts it down, pulsing expired at zero.
module interval_timer
    import tl_timer_pkg::*;
#(
    parameter int VALUE_W     = VALUE_W_DEF,
    parameter int INTERVAL_W  = INTERVAL_W_DEF,
    parameter int CLK_PER_SEC = 10
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start_Timer,
    input  logic [INTERVAL_W-1:0] interval_req,
    input  logic                  Prog_Sync,
    input  logic [VALUE_W-1:0]    value,
    output logic [INTERVAL_W-1:0] interval,
    output logic                  expired,
    output logic                  busy,
    output logic [VALUE_W-1:0]    remaining
);

    localparam logic [VALUE_W-1:0] ONE = VALUE_W'(1);

    timer_state_e          state_q, state_d;
    logic [VALUE_W-1:0]    count_q, count_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d;
    logic                  expired_q, expired_d;
    logic                  div_clr;
    logic                  tick;

    sec_tick_divider #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_div (
        .clk  (clk),
        .Reset(Reset),
        .clr  (div_clr),
        .tick (tick)
    );

    // Prog_Sync beats Start_Timer beats the tick; a restart discards the
    // count even on the edge that would otherwise have expired it.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        interval_d = interval_q;
        expired_d  = 1'b0;
        div_clr    = 1'b0;
        if (Prog_Sync) begin
            state_d = IDLE;
            count_d = '0;
        end else if (Start_Timer) begin
            state_d    = REQ;
            interval_d = interval_req;
            count_d    = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                REQ:  state_d = LOAD;
                LOAD: begin
                    count_d = value;
                    div_clr = 1'b1;
                    if (value == '0) begin
                        expired_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick && (count_q != '0)) begin
                        count_d = count_q - ONE;
                        if (count_q == ONE) begin
                            expired_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            interval_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            interval_q <= interval_d;
            expired_q  <= expired_d;
        end
    end

    assign interval  = interval_q;
    assign expired   = expired_q;
    assign busy      = (state_q != IDLE);
    assign remaining = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer with a TimeParameter stand-in (base=6, ext=3, yel=2).
module tb_interval_timer;

    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start_Timer = 1'b0;
    logic [1:0] interval_req = 2'b00;
    logic       Prog_Sync = 1'b0;
    logic [3:0] value = 4'd0;
    logic [1:0] interval;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] yel_val = 4'd2;

    interval_timer #(
        .VALUE_W    (4),
        .INTERVAL_W (2),
        .CLK_PER_SEC(CPS)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Start_Timer (Start_Timer),
        .interval_req(interval_req),
        .Prog_Sync   (Prog_Sync),
        .value       (value),
        .interval    (interval),
        .expired     (expired),
        .busy        (busy),
        .remaining   (remaining)
    );

    // Clock and TimeParameter stand-in (registered lookup of interval)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (interval)
            2'b00:   value <= 4'd6;
            2'b01:   value <= 4'd3;
            2'b10:   value <= yel_val;
            default: value <= 4'd5;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a timing run is "active" from its accepted start edge
    // until start+2+value*CPS; remaining is derived from elapsed edges.
    int         e = 0;
    bit         m_ok = 0;
    bit         m_act = 0;
    int         m_start = 0;
    int         m_val = 0;
    bit         m_exp = 0;
    logic [1:0] m_int = 2'b00;
    int         m_rem;

    always @(posedge clk) begin
        e++;
        m_exp = 0;
        if (Reset) begin
            m_ok  = 1;
            m_act = 0;
            m_int = 2'b00;
        end else if (Prog_Sync) begin
            m_act = 0;
        end else if (Start_Timer) begin
            m_act   = 1;
            m_start = e;
            m_int   = interval_req;
            m_val   = 0;
        end else if (m_act && e == m_start + 2) begin
            m_val = int'(value);
            if (m_val == 0) begin
                m_act = 0;
                m_exp = 1;
            end
        end else if (m_act && e == m_start + 2 + m_val * CPS) begin
            m_act = 0;
            m_exp = 1;
        end
        if (!m_act || e < m_start + 2) m_rem = 0;
        else m_rem = m_val - (e - m_start - 2) / CPS;
        #1;
        if (m_ok) begin
            check("model_interval", int'(interval), int'(m_int));
            check("model_expired", int'(expired), int'(m_exp));
            check("model_busy", int'(busy), int'(m_act));
            check("model_remaining", int'(remaining), m_rem);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [1:0] req);
        Start_Timer  = 1'b1;
        interval_req = req;
        cyc(1);
        Start_Timer  = 1'b0;
    endtask

    initial begin
        // Reset for two cycles
        cyc(2);
        Reset = 1'b0;
        check("rst_interval", int'(interval), 0);
        check("rst_expired", int'(expired), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_remaining", int'(remaining), 0);
        cyc(2);

        // Extended interval: 3 seconds
        start(2'b01);
        check("ext_interval_at_N", int'(interval), 1);
        check("ext_busy_at_N", int'(busy), 1);
        cyc(2);
        check("ext_load", int'(remaining), 3);
        cyc(4);
        check("ext_dec1", int'(remaining), 2);
        cyc(4);
        check("ext_dec2", int'(remaining), 1);
        cyc(3);
        check("ext_not_yet", int'(expired), 0);
        cyc(1);
        check("ext_expired", int'(expired), 1);
        check("ext_busy_low", int'(busy), 0);
        cyc(1);
        check("ext_pulse_one", int'(expired), 0);
        cyc(2);

        // Zero-length yellow
        yel_val = 4'd0;
        start(2'b10);
        cyc(2);
        check("zero_expired", int'(expired), 1);
        check("zero_busy", int'(busy), 0);
        cyc(1);
        check("zero_pulse_one", int'(expired), 0);
        yel_val = 4'd2;
        cyc(2);

        // Prog_Sync abort with remaining=4
        start(2'b00);
        cyc(10);
        check("base_rem4", int'(remaining), 4);
        Prog_Sync = 1'b1;
        cyc(1);
        Prog_Sync = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_remaining", int'(remaining), 0);
        check("abort_interval", int'(interval), 0);
        cyc(30);
        start(2'b01);
        cyc(14);
        check("after_abort_expired", int'(expired), 1);
        cyc(2);

        // Restart on the final tick of an ext count
        start(2'b01);
        cyc(13);
        Start_Timer  = 1'b1;
        interval_req = 2'b10;
        cyc(1);
        Start_Timer  = 1'b0;
        check("restart_no_expiry", int'(expired), 0);
        check("restart_interval", int'(interval), 2);
        check("restart_busy", int'(busy), 1);
        cyc(9);
        check("yel_not_yet", int'(expired), 0);
        cyc(1);
        check("yel_expired", int'(expired), 1);
        cyc(2);

        // Reset mid-RUN with remaining=2
        start(2'b00);
        cyc(18);
        check("pre_reset_rem", int'(remaining), 2);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        check("midrst_interval", int'(interval), 0);
        check("midrst_expired", int'(expired), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_remaining", int'(remaining), 0);
        cyc(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Countdown engine paired with TimeParameter. It selects which programmed interval to fetch, captures the returned 4-bit seconds value, and counts it down on a 1 Hz enable.
- It reports expiry to the traffic-light sequencer.
- It drives TimeParameter's interval input and consumes its value output; Prog_Sync reprogramming aborts any running count.

Parameters:
- VALUE_W, 4, width of the seconds value and down-counter.
- INTERVAL_W, 2, width of the interval select code.
- CLK_PER_SEC, 10, clk cycles per one-second tick. Must be ≥2; the bench uses 4.

Ports:
- clk  in  1  single system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start_Timer  in  1  one-cycle request to start timing interval_req.
- interval_req  in  INTERVAL_W  interval code requested by the sequencer: 00 base, 01 extended, 10 yellow, 11 passed through unchanged.
- Prog_Sync  in  1  reprogramming strobe from the sync stage; aborts the count.
- value  in  VALUE_W  seconds value returned by TimeParameter.
- interval  out  INTERVAL_W  registered select driven to TimeParameter.
- expired  out  1  one-cycle pulse when the count reaches zero.
- busy  out  1  high while in REQ, LOAD or RUN.
- remaining  out  VALUE_W  current down-counter contents.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (Reset). Every flop clears on the edge where Reset=1.
- Reset values: state=IDLE, interval=00, expired=0, busy=0, remaining=0, divider count=0.
- States:
  - IDLE: Start_Timer=1 at edge N → interval<=interval_req, go to REQ.
  - REQ: one wait cycle so TimeParameter's registered value settles → go to LOAD.
  - LOAD: edge N+2 → count<=value and divider cleared.
    - If value≠0, go to RUN.
    - If value==0, expired<=1 for one cycle and go to IDLE (zero-length interval).
  - RUN: on each edge with tick=1, count<=count-1.
    - If count==1 at that tick: count<=0, expired<=1 for one cycle, go to IDLE.
- Tick: divider counts 0..CLK_PER_SEC-1 and wraps. tick=1 when the divider is at CLK_PER_SEC-1. The divider is cleared in LOAD, so every second is full length.
- Timing: decrements occur at edges N+2+k·CLK_PER_SEC. expired is high in the cycle after edge N+2+value·CLK_PER_SEC.
- Priority (high→low): Reset, Prog_Sync, Start_Timer, tick.
  - Prog_Sync=1 in any state → state IDLE, count<=0, no expired pulse. interval holds its last value.
  - Start_Timer in REQ/LOAD/RUN → restart. Re-enter REQ with the new interval_req, discarding the current count. This also applies on the same edge as the final tick: restart wins and no expired pulse is issued.
  - Start_Timer in IDLE in the cycle expired is high → normal start.
- Widths: count never underflows. Decrement only when count≠0. There are no wrap-around paths.
- interval stays stable from REQ through RUN and changes only on an accepted Start_Timer.
- Reset mid-RUN → all reset values at the next edge; a pending expiry is lost.

Decomposition:
- Shared package tl_timer_pkg:
  - interval codes INT_BASE=2'b00, INT_EXT=2'b01, INT_YEL=2'b10.
  - state encoding IDLE/REQ/LOAD/RUN.
  - default VALUE_W and INTERVAL_W.
- Sub-module sec_tick_divider (clk, Reset, clr, tick; parameter CLK_PER_SEC) is instantiated once. The FSM and down-counter stay in interval_timer.

Test Plan (CLK_PER_SEC=4, TimeParameter model returns base=6, ext=3, yel=2 one cycle after interval changes):
- Reset held 2 cycles, then released → interval=00, expired=0, busy=0, remaining=0.
- Start_Timer with interval_req=01 at edge N → interval=01 from N; remaining=3 after N+2; decrements at N+6, N+10; expired high for exactly one cycle after N+14; busy low from then.
- Model returns value=0 for yellow, Start_Timer with req=10 → expired pulse right after N+2, busy drops, no RUN cycles.
- Base interval running (remaining=4), Prog_Sync=1 one cycle → IDLE next edge, remaining=0, no expired pulse ever. Then Start_Timer with req=01 → normal 3-second count.
- Start_Timer with req=10 asserted on the same edge as the final tick of an ext count → no expired pulse; interval=10; yellow count of 2 completes 2+8 edges later.
- Reset asserted mid-RUN with remaining=2 → next edge all outputs at reset values; no later expired pulse without a new Start_Timer.
